// File: rtl/arduboy_top.sv
// arduFPGA iCE40UP5K bring-up top: OLED reset/init sequencer with SPI frame streaming,
// button-to-RGB mirror, UART echo with a one-byte holding register, frame counter on D0-D7.
module arduboy_top #(
    parameter int RST_CYCLES  = 16,
    parameter int SPI_DIV     = 2,
    parameter int BAUD_DIV    = 16,
    parameter int FRAME_BYTES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    output logic RGB0, RGB1, RGB2,
    output logic OLED_DC, OLED_SS, OLED_RST,
    output logic SCK, MOSI,
    input  logic MISO,
    input  logic BTN_UP, BTN_DN, BTN_BACK, BTN_OK, BTN_INTERRUPT,
    output logic DES_SS, uSD_SS, APP_SS, ADC_SS,
    input  logic uSD_CD,
    output logic UART_TX,
    input  logic UART_RX,
    output logic D0_P, D1_P, D2_P, D3_P, D4_P, D5_P, D6_P, D7_P,
    output logic D0_N, D1_N, D2_N, D3_N, D4_N, D5_N, D6_N, D7_N
);

    localparam int IDX_W = (FRAME_BYTES > 128) ? $clog2(FRAME_BYTES) + 1 : 8;

    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_INIT, S_GAP, S_FRAME} seq_e;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_e;

    logic unused_inputs;
    assign unused_inputs = ^{MISO, uSD_CD};

    assign {DES_SS, uSD_SS, APP_SS, ADC_SS} = 4'b1111;

    // ---------------- buttons ----------------
    logic [4:0] btn_s1_q, btn_s2_q, mask;
    logic [2:0] rgb_q;

    assign mask = ~btn_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q <= 5'h1f;
            btn_s2_q <= 5'h1f;
            rgb_q    <= 3'b000;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value of its source.
            btn_s1_q <= {BTN_INTERRUPT, BTN_OK, BTN_BACK, BTN_DN, BTN_UP};
            btn_s2_q <= btn_s1_q;
            rgb_q    <= {mask[4], mask[1] | mask[2], mask[0] | mask[3]};
        end
    end

    assign {RGB2, RGB1, RGB0} = rgb_q;

    // ---------------- OLED sequencer + SPI ----------------
    seq_e             state_q;
    logic [15:0]      cnt_q;
    logic [7:0]       div_q;
    logic [2:0]       bit_q;
    logic [7:0]       sh_q;
    logic [IDX_W-1:0] byte_idx_q, next_idx;
    logic [4:0]       frame_mask_q;
    logic [7:0]       fc_q, next_byte;
    logic             oled_rst_q, ss_q, dc_q, sck_q, mosi_q, last_byte;

    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'hAE;
            4'd1:    return 8'hD5;
            4'd2:    return 8'h80;
            4'd3:    return 8'hA8;
            4'd4:    return 8'h3F;
            4'd5:    return 8'h8D;
            4'd6:    return 8'h14;
            4'd7:    return 8'h20;
            4'd8:    return 8'h00;
            default: return 8'hAF;
        endcase
    endfunction

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_idx  = byte_idx_q + IDX_W'(1);
        next_byte = next_idx[7:0] ^ {3'b000, frame_mask_q};
        last_byte = (byte_idx_q == IDX_W'(FRAME_BYTES - 1));
        if (state_q == S_INIT) begin
            next_byte = init_byte(next_idx[3:0]);
            last_byte = (byte_idx_q == IDX_W'(9));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            byte_idx_q   <= '0;
            frame_mask_q <= '0;
            fc_q         <= '0;
            oled_rst_q   <= 1'b0;
            ss_q         <= 1'b1;
            dc_q         <= 1'b0;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == 16'(RST_CYCLES - 1)) begin
                        cnt_q      <= '0;
                        oled_rst_q <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == 16'(RST_CYCLES - 1)) begin
                        cnt_q      <= '0;
                        state_q    <= S_INIT;
                        ss_q       <= 1'b0;
                        byte_idx_q <= '0;
                        div_q      <= '0;
                        bit_q      <= '0;
                        sh_q       <= 8'hAE;
                        mosi_q     <= 1'b1;
                    end
                end
                S_INIT, S_FRAME: begin
                    div_q <= div_q + 8'd1;
                    if (div_q == 8'(SPI_DIV - 1)) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        // Trailing SCK edge closes the bit; MOSI moves only while SCK is low.
                        if (sck_q) begin
                            bit_q <= bit_q + 3'd1;
                            sh_q  <= {sh_q[6:0], 1'b0};
                            mosi_q <= sh_q[6];
                            if (bit_q == 3'd7) begin
                                byte_idx_q <= next_idx;
                                sh_q       <= next_byte;
                                mosi_q     <= next_byte[7];
                                if (last_byte) begin
                                    ss_q    <= 1'b1;
                                    mosi_q  <= 1'b0;
                                    state_q <= S_GAP;
                                    cnt_q   <= '0;
                                    if (state_q == S_FRAME) fc_q <= fc_q + 8'd1;
                                end
                            end
                        end
                    end
                end
                S_GAP: begin
                    dc_q  <= 1'b1;
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q == 16'(2 * SPI_DIV)) begin
                        cnt_q        <= '0;
                        state_q      <= S_FRAME;
                        ss_q         <= 1'b0;
                        byte_idx_q   <= '0;
                        div_q        <= '0;
                        bit_q        <= '0;
                        frame_mask_q <= mask;
                        sh_q         <= {3'b000, mask};
                        mosi_q       <= 1'b0;
                    end
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    assign {OLED_RST, OLED_SS, OLED_DC, SCK, MOSI} = {oled_rst_q, ss_q, dc_q, sck_q, mosi_q};
    assign {D7_P, D6_P, D5_P, D4_P, D3_P, D2_P, D1_P, D0_P} = fc_q;
    assign {D7_N, D6_N, D5_N, D4_N, D3_N, D2_N, D1_N, D0_N} = ~fc_q;

    // ---------------- UART receiver ----------------
    rx_e        rx_state_q;
    logic       rx_s1_q, rx_s2_q, rx_prev_q, rx_valid_q;
    logic [7:0] rx_cnt_q, rx_sh_q;
    logic [2:0] rx_bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            rx_bit_q   <= '0;
        end else begin
            rx_s1_q    <= UART_RX;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_valid_q <= 1'b0;
            rx_cnt_q   <= rx_cnt_q + 8'd1;
            case (rx_state_q)
                R_IDLE: begin
                    rx_cnt_q <= '0;
                    if (rx_prev_q && !rx_s2_q) rx_state_q <= R_START;
                end
                R_START: if (rx_cnt_q == 8'(BAUD_DIV / 2 - 1)) begin
                    rx_cnt_q   <= '0;
                    rx_bit_q   <= '0;
                    rx_state_q <= rx_s2_q ? R_IDLE : R_DATA;
                end
                R_DATA: if (rx_cnt_q == 8'(BAUD_DIV - 1)) begin
                    rx_cnt_q <= '0;
                    rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_q <= rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_q <= R_STOP;
                end
                default: if (rx_cnt_q == 8'(BAUD_DIV - 1)) begin
                    rx_cnt_q   <= '0;
                    rx_valid_q <= rx_s2_q;
                    rx_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // ---------------- holding register + UART transmitter ----------------
    logic [7:0] hold_q, hold_d, tx_byte;
    logic       hold_v_q, hold_v_d, tx_start;
    logic       tx_busy_q, tx_q;
    logic [8:0] tx_sh_q;
    logic [7:0] tx_cnt_q;
    logic [3:0] tx_bit_q;

    always_comb begin
        tx_start = !tx_busy_q && (hold_v_q || rx_valid_q);
        tx_byte  = hold_v_q ? hold_q : rx_sh_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q && !tx_start;
        // A fresh byte bypasses an empty holding register when TX can start right away.
        if (rx_valid_q && !(tx_start && !hold_v_q)) begin
            hold_d   = rx_sh_q;
            hold_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_q      <= 1'b1;
            tx_sh_q   <= '1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            if (tx_start) begin
                tx_busy_q <= 1'b1;
                tx_q      <= 1'b0;
                tx_sh_q   <= {1'b1, tx_byte};
                tx_cnt_q  <= '0;
                tx_bit_q  <= '0;
            end else if (tx_busy_q) begin
                tx_cnt_q <= tx_cnt_q + 8'd1;
                if (tx_cnt_q == 8'(BAUD_DIV - 1)) begin
                    tx_cnt_q <= '0;
                    if (tx_bit_q == 4'd9) begin
                        tx_busy_q <= 1'b0;
                    end else begin
                        tx_q     <= tx_sh_q[0];
                        tx_sh_q  <= {1'b1, tx_sh_q[8:1]};
                        tx_bit_q <= tx_bit_q + 4'd1;
                    end
                end
            end
        end
    end

    assign UART_TX = tx_q;

endmodule

// File: tb/tb_arduboy_top.sv
// Self-checking bench for arduboy_top: SPI/UART scoreboards, button vector table,
// power-up timing, end-of-frame counter and reset during an SPI byte.
module tb_arduboy_top;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic RGB0, RGB1, RGB2, OLED_DC, OLED_SS, OLED_RST, SCK, MOSI;
    logic MISO = 1'b0, uSD_CD = 1'b0, UART_RX = 1'b1;
    logic BTN_UP = 1'b1, BTN_DN = 1'b1, BTN_BACK = 1'b1, BTN_OK = 1'b1, BTN_INTERRUPT = 1'b1;
    logic DES_SS, uSD_SS, APP_SS, ADC_SS, UART_TX;
    logic D0_P, D1_P, D2_P, D3_P, D4_P, D5_P, D6_P, D7_P;
    logic D0_N, D1_N, D2_N, D3_N, D4_N, D5_N, D6_N, D7_N;

    arduboy_top dut (
        .clk(clk), .rst_n(rst_n),
        .RGB0(RGB0), .RGB1(RGB1), .RGB2(RGB2),
        .OLED_DC(OLED_DC), .OLED_SS(OLED_SS), .OLED_RST(OLED_RST),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .BTN_UP(BTN_UP), .BTN_DN(BTN_DN), .BTN_BACK(BTN_BACK), .BTN_OK(BTN_OK),
        .BTN_INTERRUPT(BTN_INTERRUPT),
        .DES_SS(DES_SS), .uSD_SS(uSD_SS), .APP_SS(APP_SS), .ADC_SS(ADC_SS),
        .uSD_CD(uSD_CD), .UART_TX(UART_TX), .UART_RX(UART_RX),
        .D0_P(D0_P), .D1_P(D1_P), .D2_P(D2_P), .D3_P(D3_P),
        .D4_P(D4_P), .D5_P(D5_P), .D6_P(D6_P), .D7_P(D7_P),
        .D0_N(D0_N), .D1_N(D1_N), .D2_N(D2_N), .D3_N(D3_N),
        .D4_N(D4_N), .D5_N(D5_N), .D6_N(D6_N), .D7_N(D7_N)
    );

    logic [7:0] d_p, d_n;
    logic [2:0] rgb;
    assign d_p = {D7_P, D6_P, D5_P, D4_P, D3_P, D2_P, D1_P, D0_P};
    assign d_n = {D7_N, D6_N, D5_N, D4_N, D3_N, D2_N, D1_N, D0_N};
    assign rgb = {RGB2, RGB1, RGB0};

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // ---------------- SPI scoreboard ----------------
    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } spi_exp_t;

    spi_exp_t   spi_q[$];
    bit         spi_en = 1'b0;
    int         spi_bits = 0;
    logic [7:0] spi_sh = '0;
    logic       sck_prev = 1'b0;
    int         cyc = 0;
    int         last_rise = 0;
    bit         have_rise = 1'b0;

    always @(negedge clk) begin
        spi_exp_t e;
        cyc++;
        if (!rst_n || OLED_SS) begin
            spi_bits  = 0;
            have_rise = 1'b0;
            if (OLED_SS) check("sck_idle_when_ss_high", 32'(SCK), 32'd0);
        end else if (SCK && !sck_prev) begin
            if (have_rise) check("sck_period", 32'(cyc - last_rise), 32'd4);
            last_rise = cyc;
            have_rise = 1'b1;
            spi_sh    = {spi_sh[6:0], MOSI};
            spi_bits++;
            if (spi_bits == 8) begin
                spi_bits = 0;
                if (spi_en) begin
                    if (spi_q.size() == 0) begin
                        flag_fail("spi_unexpected_byte", $sformatf("got 0x%02h with nothing expected", spi_sh));
                    end else begin
                        e = spi_q.pop_front();
                        check("spi_byte_dc_data", 32'({OLED_DC, spi_sh}), 32'({e.dc, e.data}));
                    end
                end
            end
        end
        sck_prev = SCK;
    end

    // ---------------- UART scoreboard ----------------
    logic [7:0] uart_q[$];
    int         uart_got = 0;

    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n && UART_TX === 1'b0) begin
                repeat (8) @(negedge clk);
                check("uart_tx_start_bit", 32'(UART_TX), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = UART_TX;
                end
                repeat (16) @(negedge clk);
                check("uart_tx_stop_bit", 32'(UART_TX), 32'd1);
                uart_got++;
                if (uart_q.size() == 0) flag_fail("uart_unexpected_byte", $sformatf("got 0x%02h", b));
                else check("uart_echo_byte", 32'(b), 32'(uart_q.pop_front()));
            end
        end
    end

    task automatic uart_send(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) uart_q.push_back(b);
        @(negedge clk) UART_RX = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            repeat (16) @(negedge clk);
        end
        UART_RX = stop_bit;
        repeat (16) @(negedge clk);
        UART_RX = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    // ---------------- helpers ----------------
    localparam logic [7:0] ROM[10] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'h20, 8'h00, 8'hAF};

    task automatic push_init();
        spi_exp_t e;
        for (int i = 0; i < 10; i++) begin
            e.dc   = 1'b0;
            e.data = ROM[i];
            spi_q.push_back(e);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_oled_rst"}, 32'(OLED_RST), 32'd0);
        check({tag, "_oled_ss"}, 32'(OLED_SS), 32'd1);
        check({tag, "_sck"}, 32'(SCK), 32'd0);
        check({tag, "_mosi"}, 32'(MOSI), 32'd0);
        check({tag, "_uart_tx"}, 32'(UART_TX), 32'd1);
        check({tag, "_d_p"}, 32'(d_p), 32'h00);
        check({tag, "_d_n"}, 32'(d_n), 32'hff);
        check({tag, "_other_ss"}, 32'({DES_SS, uSD_SS, APP_SS, ADC_SS}), 32'hf);
    endtask

    // Release reset between edges, then count rising edges to OLED_RST rise and first SS fall.
    task automatic release_and_powerup();
        int rst_rise = -1;
        int ss_fall = -1;
        @(negedge clk) rst_n = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (rst_rise < 0 && OLED_RST === 1'b1) rst_rise = n;
            if (OLED_SS === 1'b0) begin
                ss_fall = n;
                break;
            end
        end
        check("oled_rst_rise_clock", 32'(rst_rise), 32'd16);
        check("first_ss_fall_window", 32'(ss_fall >= 32 && ss_fall <= 34), 32'd1);
    endtask

    typedef struct {
        logic [4:0] btn;   // {INTERRUPT, OK, BACK, DN, UP}, active-low
        logic [2:0] rgb;   // {RGB2, RGB1, RGB0}
    } btn_vec_t;

    // ---------------- main sequence ----------------
    initial begin
        btn_vec_t vecs[8];
        logic [2:0] prev_rgb;
        spi_exp_t e;
        int k;

        vecs[0] = '{5'b11110, 3'b001};
        vecs[1] = '{5'b10111, 3'b001};
        vecs[2] = '{5'b01111, 3'b100};
        vecs[3] = '{5'b11101, 3'b010};
        vecs[4] = '{5'b11011, 3'b010};
        vecs[5] = '{5'b00000, 3'b111};
        vecs[6] = '{5'b11111, 3'b000};
        vecs[7] = '{5'b11110, 3'b001};

        BTN_UP = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        check("reset_dc", 32'(OLED_DC), 32'd0);
        check("reset_rgb", 32'(rgb), 32'd0);

        push_init();
        for (int i = 0; i < 1024; i++) begin
            e.dc   = 1'b1;
            e.data = 8'(i) ^ 8'h01;
            spi_q.push_back(e);
        end
        spi_en = 1'b1;
        release_and_powerup();

        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (OLED_DC === 1'b1 && OLED_SS === 1'b0) break;
        end
        check("frame_start_seen", 32'(k < 2000), 32'd1);
        check("init_bytes_consumed", 32'(spi_q.size()), 32'd1024);

        prev_rgb = rgb;
        foreach (vecs[i]) begin
            @(negedge clk) {BTN_INTERRUPT, BTN_OK, BTN_BACK, BTN_DN, BTN_UP} = vecs[i].btn;
            repeat (2) @(posedge clk);
            #1 check($sformatf("rgb_not_early_%0d", i), 32'(rgb), 32'(prev_rgb));
            @(posedge clk);
            #1 check($sformatf("rgb_vec_%0d", i), 32'(rgb), 32'(vecs[i].rgb));
            prev_rgb = vecs[i].rgb;
        end
        {BTN_INTERRUPT, BTN_OK, BTN_BACK, BTN_DN, BTN_UP} = 5'b11111;

        uart_send(8'hA5, 1'b1);
        uart_send(8'h5A, 1'b1);
        uart_send(8'h3C, 1'b0);
        repeat (400) @(negedge clk);
        check("uart_bytes_echoed", 32'(uart_got), 32'd2);
        check("uart_queue_empty", 32'(uart_q.size()), 32'd0);

        for (k = 0; k < 70000; k++) begin
            @(negedge clk);
            if (d_p !== 8'h00) break;
        end
        check("frame_end_seen", 32'(k < 70000), 32'd1);
        check("frame_end_d_p", 32'(d_p), 32'h01);
        check("frame_end_d_n", 32'(d_n), 32'hfe);
        check("frame_bytes_consumed", 32'(spi_q.size()), 32'd0);
        spi_en = 1'b0;

        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (OLED_SS === 1'b0 && SCK === 1'b1) break;
        end
        check("mid_byte_found", 32'(k < 200), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midbyte");
        spi_q.delete();
        push_init();
        spi_en = 1'b1;
        repeat (3) @(negedge clk);
        release_and_powerup();
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (spi_q.size() == 0) break;
        end
        check("restart_init_bytes", 32'(spi_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
